// File: rtl/cafe_pkg.sv
// Shared types and constants for the coffee drink-preparation sequencer.
package cafe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AGUA,
        CAFE,
        CHOCOLATE,
        LECHE,
        ESPUMA,
        ENTREGA
    } estado_t;

    localparam logic [1:0] EXPRESO   = 2'b00;
    localparam logic [1:0] CON_LECHE = 2'b01;
    localparam logic [1:0] CAPUCCINO = 2'b10;
    localparam logic [1:0] MOCACCINO = 2'b11;

    localparam int ACT_W       = 6;
    localparam int ACT_AGUA    = 0;
    localparam int ACT_CAFE    = 1;
    localparam int ACT_CHOCO   = 2;
    localparam int ACT_LECHE   = 3;
    localparam int ACT_ESPUMA  = 4;
    localparam int ACT_ENTREGA = 5;

    // One-hot actuator drive for a step; IDLE drives nothing.
    function automatic logic [ACT_W-1:0] actuador_de(estado_t e);
        logic [ACT_W-1:0] a;
        a = '0;
        case (e)
            AGUA:      a[ACT_AGUA]    = 1'b1;
            CAFE:      a[ACT_CAFE]    = 1'b1;
            CHOCOLATE: a[ACT_CHOCO]   = 1'b1;
            LECHE:     a[ACT_LECHE]   = 1'b1;
            ESPUMA:    a[ACT_ESPUMA]  = 1'b1;
            ENTREGA:   a[ACT_ENTREGA] = 1'b1;
            default:   a = '0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/temporizador.sv
// Step-duration down-counter: loads duration-1 on step entry, flags done at zero.
module temporizador #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] dur_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= dur_i - CNT_W'(1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/preparador_cafe.sv
// Drink-preparation sequencer: runs the recipe selected by tipoCafe as timed actuator steps.
// Optional drink counter output `tazas` is enabled by defining CONTADOR_TAZAS_EN.
module preparador_cafe
    import cafe_pkg::*;
#(
    parameter int CNT_W     = 4,
    parameter int T_AGUA    = 4,
    parameter int T_CAFE    = 3,
    parameter int T_CHOC    = 2,
    parameter int T_LECHE   = 2,
    parameter int T_ESPUMA  = 2,
    parameter int T_ENTREGA = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iniciar,
    input  logic [1:0]       tipoCafe,
    input  logic             cancelar,
    output logic [ACT_W-1:0] actuadores,
    output logic             ocupado,
    output logic             listo,
`ifdef CONTADOR_TAZAS_EN
    output logic [15:0]      tazas,
`endif
    output logic             abortado
);

    localparam int T_MAX = (2 ** CNT_W) - 1;

    if (T_AGUA  < 1 || T_AGUA  > T_MAX || T_CAFE   < 1 || T_CAFE   > T_MAX ||
        T_CHOC  < 1 || T_CHOC  > T_MAX || T_LECHE  < 1 || T_LECHE  > T_MAX ||
        T_ESPUMA < 1 || T_ESPUMA > T_MAX || T_ENTREGA < 1 || T_ENTREGA > T_MAX) begin : g_bad_dur
        $error("preparador_cafe: every step duration must be in 1..2**CNT_W-1");
    end

    estado_t          state_q, state_d;
    logic [1:0]       tipo_q, tipo_d;
    logic             iniciar_prev_q;
    logic             listo_q, listo_d;
    logic             abortado_q, abortado_d;
    logic             load;
    logic [CNT_W-1:0] dur;
    logic             done;
    estado_t          nxt;

    function automatic estado_t siguiente(estado_t e, logic [1:0] t);
        estado_t s;
        s = IDLE;
        case (e)
            AGUA: s = CAFE;
            CAFE: begin
                case (t)
                    EXPRESO:   s = ENTREGA;
                    MOCACCINO: s = CHOCOLATE;
                    default:   s = LECHE;
                endcase
            end
            CHOCOLATE: s = LECHE;
            LECHE:     s = (t == CON_LECHE) ? ENTREGA : ESPUMA;
            ESPUMA:    s = ENTREGA;
            default:   s = IDLE;
        endcase
        return s;
    endfunction

    function automatic logic [CNT_W-1:0] duracion(estado_t e);
        logic [CNT_W-1:0] d;
        d = '0;
        case (e)
            AGUA:      d = CNT_W'(T_AGUA);
            CAFE:      d = CNT_W'(T_CAFE);
            CHOCOLATE: d = CNT_W'(T_CHOC);
            LECHE:     d = CNT_W'(T_LECHE);
            ESPUMA:    d = CNT_W'(T_ESPUMA);
            ENTREGA:   d = CNT_W'(T_ENTREGA);
            default:   d = '0;
        endcase
        return d;
    endfunction

    temporizador #(.CNT_W(CNT_W)) u_temporizador (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .dur_i  (dur),
        .done_o (done)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        tipo_d     = tipo_q;
        listo_d    = 1'b0;
        abortado_d = 1'b0;
        load       = 1'b0;
        nxt        = siguiente(state_q, tipo_q);

        if (state_q == IDLE) begin
            if (iniciar && !iniciar_prev_q && !cancelar) begin
                state_d = AGUA;
                tipo_d  = tipoCafe;
                load    = 1'b1;
            end
        end else if (cancelar) begin
            // Abort beats a step finishing in the same cycle, including the last one.
            state_d    = IDLE;
            abortado_d = 1'b1;
        end else if (done) begin
            state_d = nxt;
            if (nxt == IDLE) begin
                listo_d = 1'b1;
            end else begin
                load = 1'b1;
            end
        end

        dur = duracion(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            tipo_q         <= EXPRESO;
            iniciar_prev_q <= 1'b0;
            listo_q        <= 1'b0;
            abortado_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            tipo_q         <= tipo_d;
            iniciar_prev_q <= iniciar;
            listo_q        <= listo_d;
            abortado_q     <= abortado_d;
        end
    end

`ifdef CONTADOR_TAZAS_EN
    logic [15:0] tazas_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tazas_q <= '0;
        end else if (listo_d) begin
            tazas_q <= tazas_q + 16'd1;
        end
    end

    assign tazas = tazas_q;
`endif

    assign actuadores = actuador_de(state_q);
    assign ocupado    = (state_q != IDLE);
    assign listo      = listo_q;
    assign abortado   = abortado_q;

endmodule

// File: tb/tb_preparador_cafe.sv
// Self-checking bench for preparador_cafe: table of recipes plus directed reset/cancel/retrigger sequences.
module tb_preparador_cafe;

    logic       clk;
    logic       rst_n;
    logic       iniciar;
    logic [1:0] tipoCafe;
    logic       cancelar;
    logic [5:0] actuadores;
    logic       ocupado;
    logic       listo;
    logic       abortado;
`ifdef CONTADOR_TAZAS_EN
    logic [15:0] tazas;
`endif

    int total;
    int bad;
    int exp_tazas;

    localparam logic [5:0] A_AGUA = 6'h01, A_CAFE = 6'h02, A_CHOC = 6'h04,
                           A_LECH = 6'h08, A_ESPU = 6'h10, A_ENTR = 6'h20;

    preparador_cafe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iniciar    (iniciar),
        .tipoCafe   (tipoCafe),
        .cancelar   (cancelar),
        .actuadores (actuadores),
        .ocupado    (ocupado),
        .listo      (listo),
`ifdef CONTADOR_TAZAS_EN
        .tazas      (tazas),
`endif
        .abortado   (abortado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0] tipo;
        int         nsteps;
        logic [5:0] act[6];
        int         len[6];
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic start_drink(input logic [1:0] t);
        @(negedge clk);
        iniciar  = 1'b0;
        tipoCafe = t;
        @(negedge clk);
        iniciar = 1'b1;
        @(negedge clk);
    endtask

    // Runs one full drink from the table; optionally scrambles tipoCafe mid-run.
    task automatic run_drink(input int vi, input bit scramble);
        int cyc;
        cyc = 0;
        start_drink(vecs[vi].tipo);
        for (int s = 0; s < vecs[vi].nsteps; s++) begin
            for (int k = 0; k < vecs[vi].len[s]; k++) begin
                cyc++;
                check($sformatf("v%0d c%0d act", vi, cyc), 32'(actuadores), 32'(vecs[vi].act[s]));
                check($sformatf("v%0d c%0d ocupado", vi, cyc), 32'(ocupado), 32'd1);
                check($sformatf("v%0d c%0d listo", vi, cyc), 32'(listo), 32'd0);
                if (scramble && cyc == 3) tipoCafe = ~vecs[vi].tipo;
                @(negedge clk);
            end
        end
        exp_tazas++;
        check($sformatf("v%0d end listo", vi), 32'(listo), 32'd1);
        check($sformatf("v%0d end abortado", vi), 32'(abortado), 32'd0);
        check($sformatf("v%0d end ocupado", vi), 32'(ocupado), 32'd0);
        check($sformatf("v%0d end act", vi), 32'(actuadores), 32'd0);
        @(negedge clk);
        check($sformatf("v%0d listo one-shot", vi), 32'(listo), 32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_tazas = 0;

        vecs[0].tipo = 2'b00; vecs[0].nsteps = 3;
        vecs[0].act  = '{A_AGUA, A_CAFE, A_ENTR, 6'h00, 6'h00, 6'h00};
        vecs[0].len  = '{4, 3, 1, 0, 0, 0};
        vecs[1].tipo = 2'b01; vecs[1].nsteps = 4;
        vecs[1].act  = '{A_AGUA, A_CAFE, A_LECH, A_ENTR, 6'h00, 6'h00};
        vecs[1].len  = '{4, 3, 2, 1, 0, 0};
        vecs[2].tipo = 2'b10; vecs[2].nsteps = 5;
        vecs[2].act  = '{A_AGUA, A_CAFE, A_LECH, A_ESPU, A_ENTR, 6'h00};
        vecs[2].len  = '{4, 3, 2, 2, 1, 0};
        vecs[3].tipo = 2'b11; vecs[3].nsteps = 6;
        vecs[3].act  = '{A_AGUA, A_CAFE, A_CHOC, A_LECH, A_ESPU, A_ENTR};
        vecs[3].len  = '{4, 3, 2, 2, 2, 1};

        rst_n    = 1'b0;
        iniciar  = 1'b0;
        tipoCafe = 2'b00;
        cancelar = 1'b0;
        repeat (2) @(negedge clk);
        check("rst act", 32'(actuadores), 32'd0);
        check("rst ocupado", 32'(ocupado), 32'd0);
        check("rst listo", 32'(listo), 32'd0);
        check("rst abortado", 32'(abortado), 32'd0);
`ifdef CONTADOR_TAZAS_EN
        check("rst tazas", 32'(tazas), 32'd0);
`endif
        rst_n = 1'b1;

        // Asynchronous reset in the middle of the CAFE step.
        start_drink(2'b11);
        repeat (5) @(negedge clk);
        check("pre-reset act cafe", 32'(actuadores), 32'(A_CAFE));
        #2;
        rst_n   = 1'b0;
        iniciar = 1'b0;
        #1;
        check("async rst act", 32'(actuadores), 32'd0);
        check("async rst ocupado", 32'(ocupado), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("post-rst c%0d ocupado", k), 32'(ocupado), 32'd0);
            check($sformatf("post-rst c%0d listo", k), 32'(listo), 32'd0);
            check($sformatf("post-rst c%0d abortado", k), 32'(abortado), 32'd0);
        end

        for (int v = 0; v < 4; v++) begin
            run_drink(v, v == 3);
        end

        // iniciar is still high after completion: must not retrigger.
        for (int k = 0; k < 4; k++) begin
            check($sformatf("hold c%0d ocupado", k), 32'(ocupado), 32'd0);
            @(negedge clk);
        end
        run_drink(0, 1'b0);

        // Capuccino cancelled during its second LECHE cycle.
        start_drink(2'b10);
        repeat (8) @(negedge clk);
        check("cancel pre act leche", 32'(actuadores), 32'(A_LECH));
        cancelar = 1'b1;
        @(negedge clk);
        check("cancel act", 32'(actuadores), 32'd0);
        check("cancel ocupado", 32'(ocupado), 32'd0);
        check("cancel abortado", 32'(abortado), 32'd1);
        check("cancel listo", 32'(listo), 32'd0);
        cancelar = 1'b0;
        @(negedge clk);
        check("cancel abortado one-shot", 32'(abortado), 32'd0);
        check("cancel listo after", 32'(listo), 32'd0);

        // Expreso cancelled in its final ENTREGA cycle: abort wins, no listo.
        start_drink(2'b00);
        repeat (7) @(negedge clk);
        check("cancel-last pre act", 32'(actuadores), 32'(A_ENTR));
        cancelar = 1'b1;
        @(negedge clk);
        check("cancel-last abortado", 32'(abortado), 32'd1);
        check("cancel-last listo", 32'(listo), 32'd0);
        cancelar = 1'b0;
        @(negedge clk);
        check("cancel-last listo after", 32'(listo), 32'd0);

        // Rising edge of iniciar together with cancelar in IDLE: nothing happens.
        iniciar = 1'b0;
        @(negedge clk);
        iniciar  = 1'b1;
        cancelar = 1'b1;
        @(negedge clk);
        check("idle cancel ocupado", 32'(ocupado), 32'd0);
        check("idle cancel abortado", 32'(abortado), 32'd0);
        cancelar = 1'b0;
        @(negedge clk);
        check("idle cancel no late start", 32'(ocupado), 32'd0);

        // Drop and raise again: a new drink starts with AGUA.
        iniciar  = 1'b0;
        tipoCafe = 2'b01;
        @(negedge clk);
        iniciar = 1'b1;
        @(negedge clk);
        check("restart act agua", 32'(actuadores), 32'(A_AGUA));
        check("restart ocupado", 32'(ocupado), 32'd1);
        cancelar = 1'b1;
        @(negedge clk);
        check("restart abort", 32'(abortado), 32'd1);
        cancelar = 1'b0;
        @(negedge clk);

`ifdef CONTADOR_TAZAS_EN
        check("tazas count", 32'(tazas), 32'(exp_tazas));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
